// File: rtl/fmul_add_stage_pkg.sv
// Shared single-precision fmul widths and rounding-mode encodings.
// Imported by the add stage and by the normalize stage.
package fmul_add_stage_pkg;
  localparam int MANT_W = 24;
  localparam int PROD_W = 48;
  localparam int TREE_W = 40;
  localparam int EXP_W  = 10;
  localparam int RM_W   = 2;
  localparam int LOW_W  = PROD_W - TREE_W;
  localparam int FRAC_W = MANT_W - 1;
  localparam int LZC_W  = 6;

  typedef enum logic [RM_W-1:0] {
    RM_RNE = 2'd0,
    RM_RTZ = 2'd1,
    RM_RDN = 2'd2,
    RM_RUP = 2'd3
  } rm_e;
endpackage

// File: rtl/fmul_add_stage_lzc48.sv
// Combinational 48-bit leading-zero counter; all-zero input yields 48.
// Shared with the normalize stage.
module lzc48
  import fmul_add_stage_pkg::*;
(
  input  logic [PROD_W-1:0] z,
  output logic [LZC_W-1:0]  cnt
);
  // Ascending scan: the last hit is the highest set bit.
  always_comb begin
    cnt = LZC_W'(PROD_W);
    for (int i = 0; i < PROD_W; i++) begin
      if (z[i]) cnt = LZC_W'(PROD_W - 1 - i);
    end
  end
endmodule

// File: rtl/fmul_add_stage.sv
// fmul add stage: resolves Wallace sum/carry into the 48-bit product and its lzc.
// One-cycle registered latency; e=0 holds, flush kills n_valid, clrn clears all.
module fmul_add_stage
  import fmul_add_stage_pkg::*;
(
  input  logic              clk,
  input  logic              clrn,
  input  logic              e,
  input  logic              flush,
  input  logic              a_valid,
  input  logic [TREE_W-1:0] a_sum,
  input  logic [TREE_W-1:0] a_carry,
  input  logic [LOW_W-1:0]  a_z8,
  input  logic [FRAC_W-1:0] a_inf_nan_frac,
  input  logic [EXP_W-1:0]  a_exp10,
  input  logic [RM_W-1:0]   a_rm,
  input  logic              a_sign,
  input  logic              a_is_nan,
  input  logic              a_is_inf,
  output logic              n_valid,
  output logic [PROD_W-1:0] n_z48,
  output logic [LZC_W-1:0]  n_lzc,
  output logic              n_zero,
  output logic [FRAC_W-1:0] n_inf_nan_frac,
  output logic [EXP_W-1:0]  n_exp10,
  output logic [RM_W-1:0]   n_rm,
  output logic              n_sign,
  output logic              n_is_nan,
  output logic              n_is_inf
);
  logic [TREE_W-1:0] tree_sum;
  logic [PROD_W-1:0] z48;
  logic [LZC_W-1:0]  lzc;

  // Carry out of the top tree bit is dropped by the 40-bit result width.
  assign tree_sum = a_sum + a_carry;
  assign z48      = {tree_sum, a_z8};

  lzc48 u_lzc48 (
    .z   (z48),
    .cnt (lzc)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      n_valid        <= 1'b0;
      n_z48          <= '0;
      n_lzc          <= '0;
      n_zero         <= 1'b0;
      n_inf_nan_frac <= '0;
      n_exp10        <= '0;
      n_rm           <= '0;
      n_sign         <= 1'b0;
      n_is_nan       <= 1'b0;
      n_is_inf       <= 1'b0;
    end else if (flush) begin
      n_valid <= 1'b0;
    end else if (e) begin
      // Data is captured even for bubbles; only n_valid qualifies it.
      n_valid        <= a_valid;
      n_z48          <= z48;
      n_lzc          <= lzc;
      n_zero         <= (z48 == '0);
      n_inf_nan_frac <= a_inf_nan_frac;
      n_exp10        <= a_exp10;
      n_rm           <= a_rm;
      n_sign         <= a_sign;
      n_is_nan       <= a_is_nan;
      n_is_inf       <= a_is_inf;
    end
  end
endmodule

// File: tb/tb_fmul_add_stage.sv
module tb_fmul_add_stage;
  logic        clk;
  logic        clrn;
  logic        e;
  logic        flush;
  logic        a_valid;
  logic [39:0] a_sum;
  logic [39:0] a_carry;
  logic [7:0]  a_z8;
  logic [22:0] a_inf_nan_frac;
  logic [9:0]  a_exp10;
  logic [1:0]  a_rm;
  logic        a_sign;
  logic        a_is_nan;
  logic        a_is_inf;
  logic        n_valid;
  logic [47:0] n_z48;
  logic [5:0]  n_lzc;
  logic        n_zero;
  logic [22:0] n_inf_nan_frac;
  logic [9:0]  n_exp10;
  logic [1:0]  n_rm;
  logic        n_sign;
  logic        n_is_nan;
  logic        n_is_inf;

  int checks;
  int failures;

  fmul_add_stage dut (
    .clk            (clk),
    .clrn           (clrn),
    .e              (e),
    .flush          (flush),
    .a_valid        (a_valid),
    .a_sum          (a_sum),
    .a_carry        (a_carry),
    .a_z8           (a_z8),
    .a_inf_nan_frac (a_inf_nan_frac),
    .a_exp10        (a_exp10),
    .a_rm           (a_rm),
    .a_sign         (a_sign),
    .a_is_nan       (a_is_nan),
    .a_is_inf       (a_is_inf),
    .n_valid        (n_valid),
    .n_z48          (n_z48),
    .n_lzc          (n_lzc),
    .n_zero         (n_zero),
    .n_inf_nan_frac (n_inf_nan_frac),
    .n_exp10        (n_exp10),
    .n_rm           (n_rm),
    .n_sign         (n_sign),
    .n_is_nan       (n_is_nan),
    .n_is_inf       (n_is_inf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [39:0] s, input logic [39:0] c,
                       input logic [7:0] z8);
    a_valid = v;
    a_sum   = s;
    a_carry = c;
    a_z8    = z8;
  endtask

  task automatic expect_core(input string name, input logic v, input logic [47:0] z,
                             input logic [5:0] l, input logic zr);
    checks++;
    if (n_valid !== v) begin
      failures++;
      $display("FAIL %s n_valid got=%0b exp=%0b", name, n_valid, v);
    end
    checks++;
    if (n_z48 !== z) begin
      failures++;
      $display("FAIL %s n_z48 got=%h exp=%h", name, n_z48, z);
    end
    checks++;
    if (n_lzc !== l) begin
      failures++;
      $display("FAIL %s n_lzc got=%0d exp=%0d", name, n_lzc, l);
    end
    checks++;
    if (n_zero !== zr) begin
      failures++;
      $display("FAIL %s n_zero got=%0b exp=%0b", name, n_zero, zr);
    end
  endtask

  task automatic expect_all_zero(input string name);
    checks++;
    if ({n_valid, n_z48, n_lzc, n_zero, n_inf_nan_frac, n_exp10, n_rm,
         n_sign, n_is_nan, n_is_inf} !== '0) begin
      failures++;
      $display("FAIL %s outputs not cleared v=%0b z=%h l=%0d zr=%0b f=%h x=%h rm=%0d s=%0b nan=%0b inf=%0b",
               name, n_valid, n_z48, n_lzc, n_zero, n_inf_nan_frac, n_exp10, n_rm,
               n_sign, n_is_nan, n_is_inf);
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0; e = 1'b1; flush = 1'b0;
    drive(1'b1, 40'hFF_FFFF_FFFF, 40'h1, 8'hFF);
    a_inf_nan_frac = 23'h7F_FFFF; a_exp10 = 10'h3FF; a_rm = 2'd3;
    a_sign = 1'b1; a_is_nan = 1'b1; a_is_inf = 1'b1;
    #3;
    expect_all_zero("reset_initial");
    step();
    expect_all_zero("reset_held_over_edge");
    #2 clrn = 1'b1;
  endtask

  task automatic test_one_times_one();
    drive(1'b1, 40'h40_0000_0000, 40'h0, 8'h00);
    a_inf_nan_frac = 23'h2A_5A5A; a_exp10 = 10'h27F; a_rm = 2'd2;
    a_sign = 1'b1; a_is_nan = 1'b0; a_is_inf = 1'b1;
    step();
    expect_core("one_x_one", 1'b1, 48'h4000_0000_0000, 6'd1, 1'b0);
    checks++;
    if ({n_inf_nan_frac, n_exp10, n_rm, n_sign, n_is_nan, n_is_inf} !==
        {23'h2A_5A5A, 10'h27F, 2'd2, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL passthru got=%h/%h/%0d/%0b%0b%0b exp=2a5a5a/27f/2/101",
               n_inf_nan_frac, n_exp10, n_rm, n_sign, n_is_nan, n_is_inf);
    end
    a_sign = 1'b0; a_is_inf = 1'b0; a_is_nan = 1'b1; a_rm = 2'd1; a_exp10 = 10'h001;
  endtask

  task automatic test_small_and_wrap();
    drive(1'b1, 40'h1, 40'h1, 8'hAB);
    step();
    expect_core("small_ops", 1'b1, 48'h0000_0000_02AB, 6'd38, 1'b0);
    checks++;
    if ({n_is_nan, n_is_inf, n_rm, n_exp10} !== {1'b1, 1'b0, 2'd1, 10'h001}) begin
      failures++;
      $display("FAIL passthru2 got nan=%0b inf=%0b rm=%0d exp=%h", n_is_nan, n_is_inf, n_rm, n_exp10);
    end
    drive(1'b1, 40'h80_0000_0000, 40'h80_0000_0000, 8'h00);
    step();
    expect_core("wrap", 1'b1, 48'h0, 6'd48, 1'b1);
    drive(1'b1, 40'h80_0000_0000, 40'h0, 8'h00);
    step();
    expect_core("msb_set", 1'b1, 48'h8000_0000_0000, 6'd0, 1'b0);
    drive(1'b1, 40'h0, 40'h0, 8'h01);
    step();
    expect_core("lsb_only", 1'b1, 48'h0000_0000_0001, 6'd47, 1'b0);
    drive(1'b1, 40'hFF_FFFF_FFFF, 40'h1, 8'h80);
    step();
    expect_core("carry_chain", 1'b1, 48'h0000_0000_0080, 6'd40, 1'b0);
  endtask

  task automatic test_stall();
    drive(1'b1, 40'h12_3456_789A, 40'h0, 8'h55);
    step();
    expect_core("stall_load_a", 1'b1, 48'h1234_5678_9A55, 6'd3, 1'b0);
    e = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 40'h0, 40'h0, 8'h00);
      #2;
      expect_core("stall_no_comb_path", 1'b1, 48'h1234_5678_9A55, 6'd3, 1'b0);
      step();
      expect_core("stall_hold", 1'b1, 48'h1234_5678_9A55, 6'd3, 1'b0);
    end
    e = 1'b1;
    drive(1'b1, 40'h00_0000_1000, 40'h00_0000_1000, 8'h00);
    step();
    expect_core("stall_release_b", 1'b1, 48'h0000_0020_0000, 6'd26, 1'b0);
  endtask

  task automatic test_flush();
    flush = 1'b1; e = 1'b1;
    drive(1'b1, 40'h7F_0000_0000, 40'h0, 8'hEE);
    step();
    expect_core("flush_kill", 1'b0, 48'h0000_0020_0000, 6'd26, 1'b0);
    flush = 1'b1; e = 1'b0;
    step();
    expect_core("flush_with_stall", 1'b0, 48'h0000_0020_0000, 6'd26, 1'b0);
    flush = 1'b0; e = 1'b1;
    step();
    expect_core("after_flush", 1'b1, 48'h7F00_0000_00EE, 6'd1, 1'b0);
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 40'h00_0001_0000, 40'h00_0000_FFFF, 8'h00);
    step();
    expect_core("b2b_bubble", 1'b0, 48'h0000_01FF_FF00, 6'd23, 1'b0);
    drive(1'b1, 40'h20_0000_0000, 40'h20_0000_0000, 8'h0F);
    step();
    expect_core("b2b_op1", 1'b1, 48'h4000_0000_000F, 6'd1, 1'b0);
    drive(1'b1, 40'h00_0000_0001, 40'h00_0000_0000, 8'h00);
    step();
    expect_core("b2b_op2", 1'b1, 48'h0000_0000_0100, 6'd39, 1'b0);
  endtask

  task automatic test_async_reset();
    drive(1'b1, 40'h01_0000_0000, 40'h0, 8'h00);
    a_sign = 1'b1; a_exp10 = 10'h155;
    step();
    expect_core("pre_async", 1'b1, 48'h0100_0000_0000, 6'd7, 1'b0);
    #2 clrn = 1'b0;
    #1;
    expect_all_zero("async_reset_midcycle");
    flush = 1'b1; e = 1'b0;
    step();
    expect_all_zero("reset_over_flush_stall");
    #2 clrn = 1'b1; flush = 1'b0; e = 1'b1;
    drive(1'b1, 40'h00_8000_0000, 40'h0, 8'h00);
    step();
    expect_core("post_reset_op", 1'b1, 48'h0080_0000_0000, 6'd8, 1'b0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_one_times_one();
    test_small_and_wrap();
    test_stall();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
